// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg
// Shared types and helpers for the scan_decoder block.
//   mode_t       : operating mode of the decoder (direct select or scanning)
//   onehot()     : N-bit select -> one-hot vector, sized for the largest legal N
//   presc_width(): width of the dwell prescaler for a given DWELL
package scan_decoder_pkg;

    localparam int MAX_N     = 6;
    localparam int MAX_LINES = 64;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    function automatic logic [MAX_LINES-1:0] onehot(input logic [MAX_N-1:0] sel);
        logic [MAX_LINES-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // clog2(DWELL), but never narrower than one bit so DWELL=1 still has a register
    function automatic int presc_width(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if
// Control/status bundle between the controlling logic and scan_decoder.
//   en, mode, x, load : driven by the controller (master)
//   y, idx, wrap      : driven by the decoder (slave)
interface scan_decoder_if #(
    parameter int N = 3
);
    import scan_decoder_pkg::*;

    logic              en;
    logic              mode;
    logic [N-1:0]      x;
    logic              load;
    logic [(1<<N)-1:0] y;
    logic [N-1:0]      idx;
    logic              wrap;

    modport master (output en, mode, x, load, input y, idx, wrap);
    modport slave  (input en, mode, x, load, output y, idx, wrap);

endinterface

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec
// Purely combinational N -> 2^N binary-to-one-hot decoder.
//   sel : binary select, N bits
//   dec : one-hot result, bit sel set, 2^N bits
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]      sel,
    output logic [(1<<N)-1:0] dec
);

    always_comb begin
        dec = '0;
        for (int i = 0; i < (1 << N); i++) begin
            dec[i] = (sel == N'(i));
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder
// Registered binary-to-one-hot decoder with a scanning mode that walks one
// active line across all 2^N outputs, holding each for DWELL enabled cycles.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : scan_decoder_if slave port
//          en   - 0 blanks y and freezes idx/prescaler/mode
//          mode - 0 direct, 1 scan
//          x    - select value (direct) or load value (scan)
//          load - scan only: one-cycle pulse, idx <- x
//          y    - registered one-hot (one-cold when ACTIVE_LOW) of idx
//          idx  - registered active position
//          wrap - one-cycle pulse when a scan advance wraps idx to 0
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    scan_decoder_if.slave    bus
);

    localparam int              M        = 1 << N;
    localparam int              PW       = presc_width(DWELL);
    localparam logic [PW-1:0]   LAST     = PW'(DWELL - 1);
    localparam logic [N-1:0]    TOP_IDX  = {N{1'b1}};
    localparam logic [M-1:0]    INACTIVE = (ACTIVE_LOW != 0) ? {M{1'b1}} : {M{1'b0}};

    mode_t          mode_q, mode_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [M-1:0]   y_q, y_d, dec;
    logic           wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_DIRECT;
            idx_q   <= '0;
            presc_q <= '0;
            y_q     <= INACTIVE;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    // With en low everything holds; otherwise mode_q follows mode and the
    // position is chosen by direct select, scan entry, load or dwell advance.
    always_comb begin
        mode_d  = mode_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        if (bus.en) begin
            mode_d = bus.mode ? MODE_SCAN : MODE_DIRECT;
            if (!bus.mode) begin
                idx_d   = bus.x;
                presc_d = '0;
            end else if (mode_q == MODE_DIRECT) begin
                idx_d   = bus.load ? bus.x : '0;
                presc_d = '0;
            end else if (bus.load) begin
                idx_d   = bus.x;
                presc_d = '0;
            end else if (presc_q == LAST) begin
                idx_d   = idx_q + N'(1);
                presc_d = '0;
                wrap_d  = (idx_q == TOP_IDX);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Decoding the next index keeps y and idx consistent on the same edge.
    onehot_dec #(.N(N)) u_dec (
        .sel (idx_d),
        .dec (dec)
    );

    always_comb begin
        y_d = INACTIVE;
        if (bus.en) begin
            y_d = dec ^ INACTIVE;
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder
// Self-checking bench for scan_decoder: a table of direct-mode vectors plus
// hand-written scan, load, pause, reset and active-low sequences.
module tb_scan_decoder;
    import scan_decoder_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    scan_decoder_if #(.N(3)) bus_a ();
    scan_decoder_if #(.N(2)) bus_b ();

    scan_decoder #(.N(3), .DWELL(4), .ACTIVE_LOW(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    scan_decoder #(.N(2), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] x;
        logic       load;
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
    } vec_t;

    vec_t vecs[12];

    task automatic apply_stimulus(input logic en, input logic mode, input logic [2:0] x, input logic load);
        bus_a.en   = en;
        bus_a.mode = mode;
        bus_a.x    = x;
        bus_a.load = load;
    endtask

    task automatic apply_stimulus_b(input logic en, input logic mode, input logic [1:0] x, input logic load);
        bus_b.en   = en;
        bus_b.mode = mode;
        bus_b.x    = x;
        bus_b.load = load;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string name, input logic [7:0] y, input logic [2:0] idx, input logic wrap);
        check_output({name, " y"},    64'(bus_a.y),    64'(y));
        check_output({name, " idx"},  64'(bus_a.idx),  64'(idx));
        check_output({name, " wrap"}, 64'(bus_a.wrap), 64'(wrap));
    endtask

    task automatic check_b(input string name, input logic [3:0] y, input logic [1:0] idx, input logic wrap);
        check_output({name, " y"},    64'(bus_b.y),    64'(y));
        check_output({name, " idx"},  64'(bus_b.idx),  64'(idx));
        check_output({name, " wrap"}, 64'(bus_b.wrap), 64'(wrap));
    endtask

    function automatic logic [7:0] y8(input int i);
        return 8'h01 << i;
    endfunction

    initial begin
        errors = 0;
        checks = 0;

        // Direct mode: en, mode, x, load -> y, idx, wrap one cycle later
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h01, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd1, 1'b0, 8'h02, 3'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'd2, 1'b1, 8'h04, 3'd2, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'd3, 1'b0, 8'h08, 3'd3, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'd4, 1'b0, 8'h10, 3'd4, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd5, 1'b1, 8'h20, 3'd5, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd6, 1'b0, 8'h40, 3'd6, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd7, 1'b0, 8'h80, 3'd7, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 3'd7, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 3'd1, 1'b0, 8'h00, 3'd7, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd3, 1'b0, 8'h08, 3'd3, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h01, 3'd0, 1'b0};

        rst = 1'b1;
        apply_stimulus(1'b1, 1'b1, 3'd4, 1'b1);
        apply_stimulus_b(1'b1, 1'b1, 2'd2, 1'b1);
        tick();
        check_a("reset_a", 8'h00, 3'd0, 1'b0);
        check_b("reset_b", 4'hF, 2'd0, 1'b0);
        check_output("reset mode_q", 64'(dut_a.mode_q), 64'(MODE_DIRECT));

        apply_stimulus_b(1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].en, vecs[i].mode, vecs[i].x, vecs[i].load);
            tick();
            check_a($sformatf("direct[%0d]", i), vecs[i].y, vecs[i].idx, vecs[i].wrap);
        end

        // Full sweep from scan entry: x is ignored on entry without load
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b1, 3'd2, 1'b0);
        for (int k = 0; k < 36; k++) begin
            int e_idx;
            logic e_wrap;
            tick();
            e_idx  = (k / 4) % 8;
            e_wrap = (k > 0) && (k % 4 == 0) && (e_idx == 0);
            check_a($sformatf("sweep[%0d]", k), y8(e_idx), 3'(e_idx), e_wrap);
        end

        // Load mid-dwell, then pause, then resume
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        tick();
        check_a("pre_load", 8'h01, 3'd0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 3'd5, 1'b1);
        tick();
        check_a("load5", 8'h20, 3'd5, 1'b0);
        apply_stimulus(1'b1, 1'b1, 3'd5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_a($sformatf("hold5[%0d]", k), 8'h20, 3'd5, 1'b0);
        end
        tick();
        check_a("adv6", 8'h40, 3'd6, 1'b0);
        tick();
        tick();
        check_a("presc2", 8'h40, 3'd6, 1'b0);
        apply_stimulus(1'b0, 1'b1, 3'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_a($sformatf("pause[%0d]", k), 8'h00, 3'd6, 1'b0);
        end
        apply_stimulus(1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        check_a("resume", 8'h40, 3'd6, 1'b0);
        tick();
        check_a("resume_adv", 8'h80, 3'd7, 1'b0);

        // Loading 0 from the top position is not a wrap
        apply_stimulus(1'b1, 1'b1, 3'd0, 1'b1);
        tick();
        check_a("load0", 8'h01, 3'd0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 3'd6, 1'b1);
        tick();
        check_a("load6", 8'h40, 3'd6, 1'b0);

        // Reset wins over load/mode/en mid-scan
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b1, 3'd3, 1'b1);
        tick();
        check_a("rst_scan", 8'h00, 3'd0, 1'b0);
        check_output("rst_scan mode_q", 64'(dut_a.mode_q), 64'(MODE_DIRECT));
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b1, 3'd3, 1'b0);
        tick();
        check_a("reentry", 8'h01, 3'd0, 1'b0);

        // Mode change while disabled applies once en returns
        apply_stimulus(1'b0, 1'b0, 3'd2, 1'b0);
        tick();
        check_a("dis_mode", 8'h00, 3'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'd2, 1'b0);
        tick();
        check_a("en_direct", 8'h04, 3'd2, 1'b0);

        // Active-low, N=2, DWELL=1 instance
        apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0);
        apply_stimulus_b(1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        check_b("al_direct2", 4'b1011, 2'd2, 1'b0);
        apply_stimulus_b(1'b0, 1'b0, 2'd2, 1'b0);
        tick();
        check_b("al_blank", 4'b1111, 2'd2, 1'b0);
        apply_stimulus_b(1'b1, 1'b1, 2'd1, 1'b1);
        tick();
        check_b("al_entry_load", 4'b1101, 2'd1, 1'b0);
        apply_stimulus_b(1'b1, 1'b1, 2'd1, 1'b0);
        tick();
        check_b("al_scan2", 4'b1011, 2'd2, 1'b0);
        tick();
        check_b("al_scan3", 4'b0111, 2'd3, 1'b0);
        tick();
        check_b("al_wrap", 4'b1110, 2'd0, 1'b1);
        tick();
        check_b("al_scan1", 4'b1101, 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
